// File: rtl/sync_down_counter_if.sv
// Control and status bundle for sync_down_counter.
// The master drives the count controls and load value.
// The slave (the counter) returns the count and its status flags.
interface sync_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             CountEn;
    logic             Load;
    logic [WIDTH-1:0] D;
    logic             Reload;
    logic [WIDTH-1:0] Q;
    logic             Zero;
    logic             Borrow;

    modport master (
        output CountEn,
        output Load,
        output D,
        output Reload,
        input  Q,
        input  Zero,
        input  Borrow
    );

    modport slave (
        input  CountEn,
        input  Load,
        input  D,
        input  Reload,
        output Q,
        output Zero,
        output Borrow
    );
endinterface

// File: rtl/sync_down_counter.sv
// Enable-gated down counter with parallel load and optional auto-reload.
// On underflow it either wraps to all-ones or reloads the last loaded
// value, and it raises Borrow for exactly the cycle that shows the
// post-underflow count. Update priority on each edge is:
// reset, then Load, then CountEn, then hold.
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    sync_down_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] reloadVal_r;
    logic             borrow_r;

    logic [WIDTH-1:0] countNext_s;
    logic [WIDTH-1:0] reloadValNext_s;
    logic             borrowNext_s;
    logic             atZero_s;

    assign atZero_s = (count_r == ZERO_VAL);

    // Next-state selection: a load beats counting; an underflow step either reloads or wraps.
    always_comb begin
        countNext_s     = count_r;
        reloadValNext_s = reloadVal_r;
        borrowNext_s    = 1'b0;
        if (bus.Load) begin
            countNext_s     = bus.D;
            reloadValNext_s = bus.D;
        end else if (bus.CountEn) begin
            if (atZero_s) begin
                borrowNext_s = 1'b1;
                if (bus.Reload) begin
                    countNext_s = reloadVal_r;
                end else begin
                    countNext_s = ONES_VAL;
                end
            end else begin
                countNext_s = count_r - ONE_VAL;
            end
        end else begin
            countNext_s     = count_r;
            reloadValNext_s = reloadVal_r;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r     <= ZERO_VAL;
            reloadVal_r <= ZERO_VAL;
            borrow_r    <= 1'b0;
        end else begin
            count_r     <= countNext_s;
            reloadVal_r <= reloadValNext_s;
            borrow_r    <= borrowNext_s;
        end
    end

    // Zero is a pure decode of the registered count, so it adds no latency.
    assign bus.Q      = count_r;
    assign bus.Borrow = borrow_r;
    assign bus.Zero   = atZero_s;

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter (WIDTH = 4).
// Directed scenarios check explicit expected sequences.
// A randomized phase checks the counter against a behavioural model
// that uses modulo arithmetic on integers.
module tb_sync_down_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    // Behavioural model state
    int mQ;
    int mR;
    bit mB;

    sync_down_counter_if #(.WIDTH(W)) bus ();

    sync_down_counter #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advances the model by one edge, using the inputs currently applied.
    task automatic model_step();
        if (reset) begin
            mQ = 0;
            mR = 0;
            mB = 1'b0;
        end else if (bus.Load) begin
            mQ = int'(bus.D);
            mR = mQ;
            mB = 1'b0;
        end else if (bus.CountEn) begin
            mB = (mQ == 0);
            if (mQ == 0 && bus.Reload) mQ = mR;
            else mQ = (mQ + MOD - 1) % MOD;
        end else begin
            mB = 1'b0;
        end
    endtask

    // One clock edge; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.CountEn = 1'b1; bus.Load = 1'b1; bus.D = 4'b1010; bus.Reload = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.Q, bus.Zero, bus.Borrow} !== {4'b0000, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset cycle %0d: Q=%b Zero=%b Borrow=%b, required Q=0000 Zero=1 Borrow=0",
                         i, bus.Q, bus.Zero, bus.Borrow);
            end
        end
        // R must be 0: a reload-mode underflow keeps Q at 0.
        reset = 1'b0; bus.Load = 1'b0; bus.Reload = 1'b1; bus.CountEn = 1'b1;
        tick();
        checks++;
        if ({bus.Q, bus.Borrow} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_R_zero: Q=%b Borrow=%b, required Q=0000 Borrow=1", bus.Q, bus.Borrow);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1; bus.Load = 1'b0; bus.CountEn = 1'b0; bus.Reload = 1'b0;
        tick();
        reset = 1'b0; bus.CountEn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] eq;
            logic       eb;
            tick();
            eq = 4'((MOD - 1 - i + MOD) % MOD);
            eb = (i == 0) || (i == 16);
            checks++;
            if ({bus.Q, bus.Zero, bus.Borrow} !== {eq, (eq == 4'b0000), eb}) begin
                errors++;
                $display("FAIL wrap step %0d: Q=%b Zero=%b Borrow=%b, required Q=%b Zero=%b Borrow=%b",
                         i, bus.Q, bus.Zero, bus.Borrow, eq, (eq == 4'b0000), eb);
            end
        end
    endtask

    task automatic test_auto_reload();
        bus.Load = 1'b1; bus.D = 4'b0101; bus.CountEn = 1'b0; bus.Reload = 1'b1;
        tick();
        checks++;
        if ({bus.Q, bus.Borrow} !== {4'b0101, 1'b0}) begin
            errors++;
            $display("FAIL reload_load: Q=%b Borrow=%b, required Q=0101 Borrow=0", bus.Q, bus.Borrow);
        end
        bus.Load = 1'b0; bus.CountEn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] eq;
            logic       eb;
            tick();
            eq = 4'(5 - (k % 6));
            eb = ((k % 6) == 0);
            checks++;
            if ({bus.Q, bus.Zero, bus.Borrow} !== {eq, (eq == 4'b0000), eb}) begin
                errors++;
                $display("FAIL reload step %0d: Q=%b Zero=%b Borrow=%b, required Q=%b Zero=%b Borrow=%b",
                         k, bus.Q, bus.Zero, bus.Borrow, eq, (eq == 4'b0000), eb);
            end
        end
    endtask

    task automatic test_load_priority();
        bus.Load = 1'b1; bus.D = 4'b0011; bus.CountEn = 1'b0; bus.Reload = 1'b0;
        tick();
        bus.Load = 1'b1; bus.D = 4'b1010; bus.CountEn = 1'b1;
        tick();
        checks++;
        if ({bus.Q, bus.Borrow} !== {4'b1010, 1'b0}) begin
            errors++;
            $display("FAIL load_priority: Q=%b Borrow=%b, required Q=1010 Borrow=0", bus.Q, bus.Borrow);
        end
        bus.Load = 1'b0;
        tick();
        checks++;
        if (bus.Q !== 4'b1001) begin
            errors++;
            $display("FAIL load_then_count: Q=%b, required Q=1001", bus.Q);
        end
        // Load of a nonzero value while Q = 0 and CountEn = 1 gives no Borrow.
        bus.Load = 1'b1; bus.D = 4'b0000;
        tick();
        bus.D = 4'b0111;
        tick();
        checks++;
        if ({bus.Q, bus.Borrow} !== {4'b0111, 1'b0}) begin
            errors++;
            $display("FAIL load_at_zero: Q=%b Borrow=%b, required Q=0111 Borrow=0", bus.Q, bus.Borrow);
        end
    endtask

    task automatic test_enable_gating();
        bus.Load = 1'b1; bus.D = 4'b0000; bus.CountEn = 1'b0; bus.Reload = 1'b0;
        tick();
        bus.Load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.Q, bus.Zero, bus.Borrow} !== {4'b0000, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL gating hold %0d: Q=%b Zero=%b Borrow=%b, required Q=0000 Zero=1 Borrow=0",
                         i, bus.Q, bus.Zero, bus.Borrow);
            end
        end
        bus.CountEn = 1'b1;
        tick();
        checks++;
        if ({bus.Q, bus.Zero, bus.Borrow} !== {4'b1111, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL gating pulse: Q=%b Zero=%b Borrow=%b, required Q=1111 Zero=0 Borrow=1",
                     bus.Q, bus.Zero, bus.Borrow);
        end
        bus.CountEn = 1'b0;
        tick();
        checks++;
        if ({bus.Q, bus.Borrow} !== {4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL gating after: Q=%b Borrow=%b, required Q=1111 Borrow=0", bus.Q, bus.Borrow);
        end
    endtask

    task automatic test_mid_reset_degenerate();
        bus.Load = 1'b1; bus.D = 4'b0110; bus.CountEn = 1'b0; bus.Reload = 1'b0;
        tick();
        bus.Load = 1'b0; bus.CountEn = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.Q !== 4'b0100) begin
            errors++;
            $display("FAIL mid_count: Q=%b, required Q=0100", bus.Q);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.Q, bus.Zero, bus.Borrow} !== {4'b0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: Q=%b Zero=%b Borrow=%b, required Q=0000 Zero=1 Borrow=0",
                     bus.Q, bus.Zero, bus.Borrow);
        end
        reset = 1'b0; bus.Reload = 1'b1; bus.CountEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.Q, bus.Borrow} !== {4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL degenerate %0d: Q=%b Borrow=%b, required Q=0000 Borrow=1", i, bus.Q, bus.Borrow);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 31) == 0);
            bus.Load    = ($urandom_range(0, 7) == 0);
            bus.CountEn = ($urandom_range(0, 3) != 0);
            bus.Reload  = 1'($urandom_range(0, 1));
            bus.D       = 4'($urandom_range(0, MOD - 1));
            tick();
            checks++;
            if ({bus.Q, bus.Zero, bus.Borrow} !== {4'(mQ), (mQ == 0), mB}) begin
                errors++;
                $display("FAIL random cycle %0d: Q=%b Zero=%b Borrow=%b, required Q=%b Zero=%b Borrow=%b",
                         i, bus.Q, bus.Zero, bus.Borrow, 4'(mQ), (mQ == 0), mB);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mQ = 0;
        mR = 0;
        mB = 1'b0;
        reset = 1'b1;
        bus.CountEn = 1'b0;
        bus.Load = 1'b0;
        bus.D = 4'b0000;
        bus.Reload = 1'b0;
        #2;
        test_reset();
        test_wrap();
        test_auto_reload();
        test_load_priority();
        test_enable_gating();
        test_mid_reset_degenerate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
